fetch_stage: RTL and testbench

Instruction-fetch stage of the rv32 pipeline, directly upstream of the decode control stage. It owns the program counter, issues word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small queue, and presents `dec_inst`/`dec_pc` to decode with a valid/ready handshake. A redirect from the execute stage (`pcSel` plus ALU target) reloads the PC, flushes the queue, and discards responses still in flight.

---
 rtl/rv32_fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 45 ++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared constants and types for the rv32 instruction-fetch stage.
package rv32_fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with clear; head is visible combinationally so the
// consumer sees an entry in the cycle after it was pushed.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rv32 fetch stage: owns the PC, issues credit-limited word requests to
// instruction memory and queues in-order responses for decode.
module fetch_stage
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL_W  = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] q_count;
    logic [CW-1:0] pcf_count;
    logic [63:0]   q_head;
    logic [31:0]   pcf_head;
    logic [CW:0]   occupancy;
    logic          deq;
    logic          credit_ok;
    logic          req_fire;
    logic          keep_rsp;
    logic          drop_rsp;

    assign dec_valid = (q_count != '0);
    assign deq       = dec_valid & dec_ready;

    // Slots already promised (in flight or queued), less the one leaving now.
    assign occupancy = {1'b0, inflight_q} + {1'b0, q_count} - {{CW{1'b0}}, deq};
    assign credit_ok = (occupancy < DEPTH_W);

    assign imem_req_valid = rst & (state_q == FETCH) & ~redirect & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign keep_rsp = imem_rsp_valid & ~redirect & (drop_q == '0);
    assign drop_rsp = imem_rsp_valid & ~redirect & (drop_q != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect) begin
            // Every outstanding request becomes a drop; a response landing
            // this cycle is one of them and is already gone.
            pc_d       = align_word(redirect_pc);
            inflight_d = '0;
            drop_d     = drop_q + inflight_q - CW'(imem_rsp_valid);
            state_d    = (drop_d != '0) ? FLUSH : FETCH;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            inflight_d = inflight_q + CW'(req_fire) - CW'(keep_rsp);
            if (drop_rsp) drop_d = drop_q - CW'(1);
            if (state_q == FLUSH && drop_d == '0) state_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (clk),
        .rst_ni  (rst),
        .push_i  (req_fire),
        .pop_i   (keep_rsp),
        .clear_i (redirect),
        .data_i  (pc_q),
        .data_o  (pcf_head),
        .count_o (pcf_count)
    );

    fetch_queue #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk     (clk),
        .rst_ni  (rst),
        .push_i  (keep_rsp),
        .pop_i   (deq),
        .clear_i (redirect),
        .data_i  ({imem_rsp_data, pcf_head}),
        .data_o  (q_head),
        .count_o (q_count)
    );

    assign dec_inst = dec_valid ? q_head[63:32] : NOP_INST;
    assign dec_pc   = dec_valid ? q_head[31:0]  : 32'h0;

    // The credit rule keeps a kept response from ever meeting a full queue,
    // and the PC side-FIFO always tracks exactly the requests in flight.
    assert property (@(posedge clk) disable iff (!rst) !(keep_rsp && q_count == FULL_W));
    assert property (@(posedge clk) disable iff (!rst) pcf_count == inflight_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fixed-latency memory model, expected decode
// transfers queued by the stimulus and checked by an independent monitor.
module tb_fetch_stage;
    import rv32_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          mem_lat = 1;
    int          cyc = 0;
    logic        hs_valid = 1'b0;
    logic [31:0] hs_addr = 32'h0;
    logic        rv_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Memory returns the bitwise inverse of the address as the instruction.
    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = ~pc;
        exp_q.push_back(e);
    endtask

    task automatic chk_req(input string name, input logic [31:0] addr);
        check(name, hs_valid ? hs_addr : 32'hDEAD_BEEF, addr);
    endtask

    // One clock: inputs were set at the negedge, memory acts after settling.
    task automatic tick();
        pend_t p;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!rst) begin
            pend_q.delete();
        end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~p.addr;
        end
        rv_seen  = imem_req_valid;
        hs_valid = rst && imem_req_valid && imem_req_ready;
        hs_addr  = imem_req_addr;
        if (hs_valid) begin
            p.addr = imem_req_addr;
            p.due  = cyc + mem_lat;
            pend_q.push_back(p);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Monitor: every decode handshake pops and compares one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected delivery: dec_pc %h, none expected", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_pc", dec_pc, e.pc);
                    check("dec_inst", dec_inst, e.inst);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        @(negedge clk);

        // Reset state
        rst = 1'b0;
        dec_ready = 1'b1;
        ticks(2);
        check("rst req_valid", 32'(rv_seen), 32'h0);
        check("rst dec_valid", 32'(dec_valid), 32'h0);
        check("rst dec_inst", dec_inst, NOP_INST);
        check("rst dec_pc", dec_pc, 32'h0);

        // Release: back-to-back fetch, 1-cycle memory
        rst = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        tick(); chk_req("req c0", 32'h0); check("dec_valid c1", 32'(dec_valid), 32'h0);
        tick(); chk_req("req c1", 32'h4); check("dec_valid c2", 32'(dec_valid), 32'h1);
        tick(); chk_req("req c2", 32'h8);
        ticks(3);

        // Decode stall: credits exhausted, nothing issued, order kept
        dec_ready = 1'b0;
        n = 0;
        repeat (5) begin
            tick();
            if (hs_valid) n++;
        end
        check("stall requests", 32'(n), 32'h0);
        expect_pc(32'h10); expect_pc(32'h14); expect_pc(32'h18);
        dec_ready = 1'b1;
        tick(); chk_req("req after stall", 32'h18);
        ticks(2);

        // Fill the queue, then reset mid-stream
        dec_ready = 1'b0;
        ticks(2);
        check("full dec_valid", 32'(dec_valid), 32'h1);
        check("full head pc", dec_pc, 32'h1C);
        rst = 1'b0;
        tick();
        check("mid rst dec_valid", 32'(dec_valid), 32'h0);
        check("mid rst dec_inst", dec_inst, NOP_INST);
        check("mid rst dec_pc", dec_pc, 32'h0);
        tick();
        check("mid rst req_valid", 32'(rv_seen), 32'h0);
        rst = 1'b1;
        dec_ready = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4);
        tick(); chk_req("refetch", 32'h0);
        ticks(3);

        // Redirect with two requests in flight, 3-cycle memory
        rst = 1'b0; dec_ready = 1'b0; mem_lat = 3;
        ticks(2);
        rst = 1'b1;
        tick(); chk_req("r3 req0", 32'h0);
        tick(); chk_req("r3 req1", 32'h4);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick(); check("r3 redirect cycle", 32'(rv_seen), 32'h0);
        redirect = 1'b0; dec_ready = 1'b1;
        tick(); check("r3 flush drop1", 32'(rv_seen), 32'h0);
        tick(); check("r3 flush drop2", 32'(rv_seen), 32'h0);
        expect_pc(32'h100); expect_pc(32'h104);
        tick(); chk_req("r3 target req", 32'h100);
        ticks(5);

        // Redirect during FLUSH and redirect+response together, 4-cycle memory
        rst = 1'b0; dec_ready = 1'b0; mem_lat = 4;
        ticks(2);
        rst = 1'b1;
        tick(); chk_req("r4 req0", 32'h0);
        tick(); chk_req("r4 req1", 32'h4);
        redirect = 1'b1; redirect_pc = 32'h180;
        tick(); check("r4 redirect a", 32'(rv_seen), 32'h0);
        redirect_pc = 32'h200;
        tick(); check("r4 redirect in flush", 32'(rv_seen), 32'h0);
        tick(); check("r4 redirect with rsp", 32'(rv_seen), 32'h0);
        redirect = 1'b0; dec_ready = 1'b1;
        tick(); check("r4 last drop", 32'(rv_seen), 32'h0);
        expect_pc(32'h200); expect_pc(32'h204);
        tick(); chk_req("r4 target req", 32'h200);
        ticks(6);

        // PC wrap at the top of memory; unaligned redirect target
        rst = 1'b0; dec_ready = 1'b0; mem_lat = 1;
        ticks(2);
        rst = 1'b1; dec_ready = 1'b1;
        tick(); chk_req("w req0", 32'h0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        tick(); chk_req("w top", 32'hFFFF_FFFC);
        tick(); chk_req("w wrap", 32'h0);
        tick();
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        expect_pc(32'h100); expect_pc(32'h104);
        tick(); chk_req("w aligned target", 32'h100);
        ticks(3);

        dec_ready = 1'b0;
        ticks(3);
        check("pending expected", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
